jk_bank_driver: RTL and testbench

- Command-driven controller for an external bank of W JK flip-flops (q/q_bar, async active-low clear) clocked on the same clk.
- Translates word-level commands (load, inc, dec, toggle/set/clear by mask) into per-bit J/K excitation using the JK excitation table.
- Drives the bank for exactly one cycle, then checks q/q_bar feedback against an internal shadow copy and flags any mismatch.
- Sits between a register-file/sequencer command source and the JK register bank.

---
 rtl/jk_bank_driver_pkg.sv | 32 +++
 rtl/jk_bank_driver_jk_excite.sv | 39 +++
 rtl/jk_bank_driver.sv | 161 ++++++++++++++++
 tb/tb_jk_bank_driver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_driver_pkg.sv
// ---------------------------------------------------------------------------
// jk_bank_driver_pkg
//   Shared definitions for the JK bank driver slice.
//   - Command opcodes carried on cmd_op (3 bits, 7 is reserved and acts as HOLD)
//   - Controller state encoding
//   - Small helper for the busy flag
// ---------------------------------------------------------------------------
package jk_bank_driver_pkg;

    // Command opcodes
    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_INC    = 3'd2;
    localparam logic [2:0] OP_DEC    = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_SET    = 3'd5;
    localparam logic [2:0] OP_CLEAR  = 3'd6;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // busy covers the two cycles a command occupies the bank
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_DRIVE) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/jk_bank_driver_jk_excite.sv
// ---------------------------------------------------------------------------
// jk_excite
//   Combinational JK excitation for a W-bit word.
//   Ports:
//     cur         in  W  present flip-flop contents
//     nxt         in  W  desired contents after one clock
//     toggle_mode in  1  drive J=K=1 on mask bits instead of using the table
//     mask        in  W  bit mask used only in toggle_mode
//     j, k        out W  excitation for the bank
//   Excitation table (don't-cares resolved to 0):
//     0->0 : J0 K0   0->1 : J1 K0   1->0 : J0 K1   1->1 : J0 K0
// ---------------------------------------------------------------------------
module jk_excite #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] nxt,
    input  logic         toggle_mode,
    input  logic [W-1:0] mask,
    output logic [W-1:0] j,
    output logic [W-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        if (toggle_mode) begin
            // Use the bank's native toggle path rather than set/reset pairs
            j = mask;
            k = mask;
        end else begin
            for (int unsigned i = 0; i < W; i++) begin
                j[i] = ~cur[i] &  nxt[i];
                k[i] =  cur[i] & ~nxt[i];
            end
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// ---------------------------------------------------------------------------
// jk_bank_driver
//   Command-driven controller for an external bank of W JK flip-flops that
//   share clk/rstn. Each accepted command is translated into one cycle of
//   J/K excitation, after which the bank's q/q_bar feedback is compared with
//   the expected value. A mismatch latches err until err_clr resynchronises
//   the shadow copy to the bank.
//   Ports:
//     clk, rstn        clock; asynchronous active-low reset (also bank clear)
//     cmd_valid/ready  command handshake, accepted on rising clk
//     cmd_op           0 HOLD 1 LOAD 2 INC 3 DEC 4 TOGGLE 5 SET 6 CLEAR 7 =HOLD
//     cmd_data         LOAD value or TOGGLE/SET/CLEAR mask
//     j_out, k_out     bank excitation
//     q_fb, q_bar_fb   bank feedback
//     shadow           expected bank contents
//     busy             high while a command occupies the bank
//     err              latched feedback mismatch
//     err_clr          leaves ERROR, shadow <= q_fb
//   Sequence per command: accept (T) -> DRIVE (T+1) -> CHECK (T+2) -> IDLE.
// ---------------------------------------------------------------------------
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [W-1:0] j_out,
    output logic [W-1:0] k_out,
    input  logic [W-1:0] q_fb,
    input  logic [W-1:0] q_bar_fb,
    output logic [W-1:0] shadow,
    output logic         busy,
    output logic         err,
    input  logic         err_clr
);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   nxt_r;
    logic [W-1:0]   nxt_d;
    logic [W-1:0]   shadow_d;
    logic [W-1:0]   j_d;
    logic [W-1:0]   k_d;
    logic           ready_d;
    logic           busy_d;
    logic           err_d;

    logic [W-1:0]   cmd_nxt;
    logic           cmd_toggle;
    logic [W-1:0]   exc_j;
    logic [W-1:0]   exc_k;
    logic           accept;
    logic           fb_ok;

    assign accept = cmd_valid && cmd_ready && (state_q == ST_IDLE);
    // Feedback is trusted only when q matches and q_bar is its exact complement
    assign fb_ok  = (q_fb == nxt_r) && (q_bar_fb == ~q_fb);

    // Next word value from the current shadow and the presented command
    always_comb begin
        cmd_nxt    = shadow;
        cmd_toggle = 1'b0;
        case (cmd_op)
            OP_LOAD:   cmd_nxt = cmd_data;
            OP_INC:    cmd_nxt = shadow + W'(1);
            OP_DEC:    cmd_nxt = shadow - W'(1);
            OP_TOGGLE: begin
                cmd_nxt    = shadow ^ cmd_data;
                cmd_toggle = 1'b1;
            end
            OP_SET:    cmd_nxt = shadow | cmd_data;
            OP_CLEAR:  cmd_nxt = shadow & ~cmd_data;
            default:   cmd_nxt = shadow;
        endcase
    end

    jk_excite #(
        .W (W)
    ) u_excite (
        .cur         (shadow),
        .nxt         (cmd_nxt),
        .toggle_mode (cmd_toggle),
        .mask        (cmd_data),
        .j           (exc_j),
        .k           (exc_k)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_r;
        shadow_d = shadow;
        j_d      = '0;
        k_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    j_d     = exc_j;
                    k_d     = exc_k;
                    nxt_d   = cmd_nxt;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // Bank captures j_out/k_out at this edge; release them now
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (fb_ok) begin
                    shadow_d = nxt_r;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    shadow_d = q_fb;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered, so derive them from the next state
        ready_d = (state_d == ST_IDLE);
        busy_d  = is_busy_state(state_d);
        err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            nxt_r     <= '0;
            shadow    <= '0;
            j_out     <= '0;
            k_out     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            nxt_r     <= nxt_d;
            shadow    <= shadow_d;
            j_out     <= j_d;
            k_out     <= k_d;
            cmd_ready <= ready_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_driver
//   Bench for jk_bank_driver with a behavioural 4-bit JK bank attached and a
//   word-level reference model of the expected bank contents and excitation.
// ---------------------------------------------------------------------------
module tb_jk_bank_driver;

    localparam int W = 4;

    localparam logic [2:0] C_HOLD   = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_INC    = 3'd2;
    localparam logic [2:0] C_DEC    = 3'd3;
    localparam logic [2:0] C_TOGGLE = 3'd4;
    localparam logic [2:0] C_SET    = 3'd5;
    localparam logic [2:0] C_CLEAR  = 3'd6;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic [W-1:0] q_fb;
    logic [W-1:0] q_bar_fb;
    logic [W-1:0] shadow;
    logic         busy;
    logic         err;
    logic         err_clr;

    int total = 0;
    int bad   = 0;

    // Behavioural JK bank plus a stuck-at-1 fault on q_fb bit 0
    logic [W-1:0] bank_q;
    logic         stuck0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                case ({j_out[i], k_out[i]})
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    assign q_fb     = bank_q | {{(W-1){1'b0}}, stuck0};
    assign q_bar_fb = ~bank_q;

    always #5 clk = ~clk;

    jk_bank_driver #(.W(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .j_out     (j_out),
        .k_out     (k_out),
        .q_fb      (q_fb),
        .q_bar_fb  (q_bar_fb),
        .shadow    (shadow),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] ref_shadow;

    function automatic logic [W-1:0] ref_next(input logic [2:0] op,
                                              input logic [W-1:0] cur,
                                              input logic [W-1:0] data);
        longint m = longint'(1) << W;
        longint c = longint'(cur);
        longint r;
        case (op)
            C_LOAD:   r = longint'(data);
            C_INC:    r = (c + 1) % m;
            C_DEC:    r = (c + m - 1) % m;
            C_TOGGLE: r = longint'(cur ^ data);
            C_SET:    r = longint'(cur | data);
            C_CLEAR:  r = longint'(cur & ~data);
            default:  r = c;
        endcase
        return W'(r);
    endfunction

    task automatic ref_exc(input logic [2:0] op, input logic [W-1:0] cur,
                           input logic [W-1:0] data,
                           output logic [W-1:0] ej, output logic [W-1:0] ek);
        logic [W-1:0] n;
        n  = ref_next(op, cur, data);
        ej = '0;
        ek = '0;
        for (int i = 0; i < W; i++) begin
            if (op == C_TOGGLE) begin
                ej[i] = data[i];
                ek[i] = data[i];
            end else if (!cur[i] && n[i]) begin
                ej[i] = 1'b1;
            end else if (cur[i] && !n[i]) begin
                ek[i] = 1'b1;
            end
        end
    endtask

    // ---------------- stimulus helper (captures, does not judge) ----------------
    logic [W-1:0] obs_j, obs_k, obs_jk_chk_j, obs_jk_chk_k, obs_shadow;
    logic         obs_busy_drv, obs_rdy_drv, obs_err, obs_rdy, obs_busy;

    // Called #1 after a rising edge; returns #1 after edge T+3
    task automatic issue(input logic [2:0] op, input logic [W-1:0] data);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL issue_timeout cmd_ready=%b required=1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid    = 1'b0;
        obs_j        = j_out;
        obs_k        = k_out;
        obs_busy_drv = busy;
        obs_rdy_drv  = cmd_ready;
        @(posedge clk); #1;
        obs_jk_chk_j = j_out;
        obs_jk_chk_k = k_out;
        @(posedge clk); #1;
        obs_shadow = shadow;
        obs_err    = err;
        obs_rdy    = cmd_ready;
        obs_busy   = busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        err_clr = 1'b0; stuck0 = 1'b0;
        ref_shadow = '0;
        #22 rstn = 1'b1;
        @(posedge clk); #1;
        total++; if (shadow !== 4'h0) begin bad++; $display("FAIL reset_shadow got=%h exp=0", shadow); end
        total++; if ({j_out, k_out} !== 8'h00) begin bad++; $display("FAIL reset_jk got=%h/%h exp=0/0", j_out, k_out); end
        total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b err=%b exp=0/0", busy, err); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_load;
        issue(C_LOAD, 4'hA);
        total++; if (obs_j !== 4'hA || obs_k !== 4'h0) begin bad++; $display("FAIL load_jk got=%h/%h exp=a/0", obs_j, obs_k); end
        total++; if (obs_busy_drv !== 1'b1 || obs_rdy_drv !== 1'b0) begin bad++; $display("FAIL load_drive_flags busy=%b rdy=%b exp=1/0", obs_busy_drv, obs_rdy_drv); end
        total++; if (obs_jk_chk_j !== 4'h0 || obs_jk_chk_k !== 4'h0) begin bad++; $display("FAIL load_check_jk got=%h/%h exp=0/0", obs_jk_chk_j, obs_jk_chk_k); end
        total++; if (obs_shadow !== 4'hA || obs_err !== 1'b0 || obs_rdy !== 1'b1) begin bad++; $display("FAIL load_done shadow=%h err=%b rdy=%b exp=a/0/1", obs_shadow, obs_err, obs_rdy); end
        ref_shadow = 4'hA;
    endtask

    task automatic test_inc;
        issue(C_INC, 4'h3);
        total++; if (obs_j !== 4'h1 || obs_k !== 4'h0 || obs_shadow !== 4'hB) begin bad++; $display("FAIL inc_a j=%h k=%h shadow=%h exp=1/0/b", obs_j, obs_k, obs_shadow); end
        issue(C_LOAD, 4'hF);
        total++; if (obs_shadow !== 4'hF) begin bad++; $display("FAIL load_f shadow=%h exp=f", obs_shadow); end
        issue(C_INC, 4'h0);
        total++; if (obs_j !== 4'h0 || obs_k !== 4'hF || obs_shadow !== 4'h0) begin bad++; $display("FAIL inc_wrap j=%h k=%h shadow=%h exp=0/f/0", obs_j, obs_k, obs_shadow); end
        ref_shadow = 4'h0;
    endtask

    task automatic test_dec_toggle;
        issue(C_DEC, 4'h9);
        total++; if (obs_j !== 4'hF || obs_k !== 4'h0 || obs_shadow !== 4'hF) begin bad++; $display("FAIL dec_wrap j=%h k=%h shadow=%h exp=f/0/f", obs_j, obs_k, obs_shadow); end
        issue(C_TOGGLE, 4'h5);
        total++; if (obs_j !== 4'h5 || obs_k !== 4'h5 || obs_shadow !== 4'hA) begin bad++; $display("FAIL toggle j=%h k=%h shadow=%h exp=5/5/a", obs_j, obs_k, obs_shadow); end
        ref_shadow = 4'hA;
    endtask

    task automatic test_back_to_back;
        int prev = -1;
        int accepts = 0;
        int n = 0;
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            cmd_op   = 3'($urandom_range(0, 7));
            cmd_data = 4'($urandom);
            total++;
            if (busy !== !cmd_ready) begin bad++; $display("FAIL b2b_busy cyc=%0d busy=%b rdy=%b exp busy=!rdy", cyc, busy, cmd_ready); end
            if (cmd_ready === 1'b1) begin
                if (prev >= 0) begin
                    total++;
                    if (cyc - prev != 3) begin bad++; $display("FAIL b2b_gap got=%0d exp=3", cyc - prev); end
                end
                total++;
                if (shadow !== ref_shadow) begin bad++; $display("FAIL b2b_shadow got=%h exp=%h", shadow, ref_shadow); end
                ref_shadow = ref_next(cmd_op, ref_shadow, cmd_data);
                prev = cyc;
                accepts++;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        while (cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        total++; if (accepts != 10) begin bad++; $display("FAIL b2b_accepts got=%0d exp=10", accepts); end
        total++; if (shadow !== ref_shadow || err !== 1'b0) begin bad++; $display("FAIL b2b_final shadow=%h err=%b exp=%h/0", shadow, err, ref_shadow); end

        issue(C_LOAD, 4'hA);
        issue(C_SET, 4'h4);
        total++; if (obs_shadow !== 4'hE) begin bad++; $display("FAIL set shadow=%h exp=e", obs_shadow); end
        issue(C_CLEAR, 4'h8);
        total++; if (obs_shadow !== 4'h6) begin bad++; $display("FAIL clear shadow=%h exp=6", obs_shadow); end
        ref_shadow = 4'h6;
    endtask

    task automatic test_random;
        logic [2:0]   op;
        logic [W-1:0] d, ej, ek;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            d  = 4'($urandom);
            ref_exc(op, ref_shadow, d, ej, ek);
            issue(op, d);
            ref_shadow = ref_next(op, ref_shadow, d);
            total++;
            if (obs_j !== ej || obs_k !== ek) begin bad++; $display("FAIL rand_jk op=%0d data=%h got=%h/%h exp=%h/%h", op, d, obs_j, obs_k, ej, ek); end
            total++;
            if (obs_shadow !== ref_shadow || obs_err !== 1'b0) begin bad++; $display("FAIL rand_shadow op=%0d got=%h err=%b exp=%h/0", op, obs_shadow, obs_err, ref_shadow); end
        end
    endtask

    task automatic test_fault;
        logic [W-1:0] ej, ek;
        stuck0 = 1'b1;
        ref_exc(C_LOAD, ref_shadow, 4'h0, ej, ek);
        issue(C_LOAD, 4'h0);
        total++; if (obs_j !== ej || obs_k !== ek) begin bad++; $display("FAIL fault_jk got=%h/%h exp=%h/%h", obs_j, obs_k, ej, ek); end
        total++; if (obs_err !== 1'b1 || obs_rdy !== 1'b0) begin bad++; $display("FAIL fault_err err=%b rdy=%b exp=1/0", obs_err, obs_rdy); end
        total++; if (obs_shadow !== ref_shadow) begin bad++; $display("FAIL fault_shadow got=%h exp=%h", obs_shadow, ref_shadow); end
        // Commands are ignored while in ERROR
        cmd_valid = 1'b1; cmd_op = C_LOAD; cmd_data = 4'h3;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        total++; if (err !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b0 || j_out !== 4'h0 || shadow !== ref_shadow) begin
            bad++; $display("FAIL fault_hold err=%b rdy=%b busy=%b j=%h shadow=%h exp=1/0/0/0/%h", err, cmd_ready, busy, j_out, shadow, ref_shadow);
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        ref_shadow = 4'h1;
        total++; if (shadow !== 4'h1 || err !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL fault_clr shadow=%h err=%b rdy=%b exp=1/0/1", shadow, err, cmd_ready); end
        stuck0 = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] ej, ek;
        ref_exc(C_LOAD, ref_shadow, 4'h7, ej, ek);
        cmd_valid = 1'b1; cmd_op = C_LOAD; cmd_data = 4'h7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        total++; if (j_out !== ej || k_out !== ek || busy !== 1'b1) begin bad++; $display("FAIL mid_drive j=%h k=%h busy=%b exp=%h/%h/1", j_out, k_out, busy, ej, ek); end
        #2 rstn = 1'b0;
        #1;
        total++; if (j_out !== 4'h0 || k_out !== 4'h0 || shadow !== 4'h0 || busy !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL mid_reset j=%h k=%h shadow=%h busy=%b err=%b exp=0/0/0/0/0", j_out, k_out, shadow, busy, err);
        end
        #2 rstn = 1'b1;
        ref_shadow = '0;
        @(posedge clk); #1;
        issue(C_HOLD, 4'hF);
        total++; if (obs_j !== 4'h0 || obs_k !== 4'h0 || obs_shadow !== 4'h0 || obs_err !== 1'b0) begin
            bad++; $display("FAIL mid_hold j=%h k=%h shadow=%h err=%b exp=0/0/0/0", obs_j, obs_k, obs_shadow, obs_err);
        end
        // err_clr outside ERROR has no effect
        issue(C_LOAD, 4'h9);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        total++; if (shadow !== 4'h9 || err !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_errclr shadow=%h err=%b rdy=%b exp=9/0/1", shadow, err, cmd_ready); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_inc;
        test_dec_toggle;
        test_back_to_back;
        test_random;
        test_fault;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
